// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_pkg
//  Purpose  : Shared constants for the pipeline stall/flush sequencer:
//             memory-handshake FSM state encodings and default parameter
//             values used by pipeline_hazard_ctrl and mem_handshake_fsm.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Memory handshake FSM state encodings
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Default parameter values
    localparam int unsigned c_REG_AW_DEF   = 5;
    localparam int unsigned c_MAX_WAIT_DEF = 255;

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_mem_handshake_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mem_handshake_fsm
//  Purpose  : Owns the req/ack handshake with the data memory for the
//             instruction in MEM. Issues the request combinationally in the
//             cycle the access is seen in IDLE, holds it through WAIT until
//             ack (or timeout), then spends exactly one DONE cycle unstalled
//             so the pipeline advances and MEM/WB captures the data.
//  Ports    : i_clk       - clock, rising edge
//             i_rst_n     - asynchronous reset, active-low
//             i_start     - enable issuing of new requests
//             i_memRd     - MEM-stage instruction is a load
//             i_memWr     - MEM-stage instruction is a store
//             i_memAck    - one-cycle completion pulse from memory
//             o_memReq    - level request to memory
//             o_memStall  - freeze pipeline while the access is in flight
//             o_timeout   - sticky: an access exceeded MAX_WAIT WAIT cycles
//  Revision : 1.0 - initial release
// ============================================================================
module mem_handshake_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = c_MAX_WAIT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_memRd,
    input  logic i_memWr,
    input  logic i_memAck,
    output logic o_memReq,
    output logic o_memStall,
    output logic o_timeout
);

    localparam int unsigned c_CNT_W = $clog2(MAX_WAIT + 1);

    logic [1:0]         r_state;
    logic [1:0]         w_stateNext;
    logic [c_CNT_W-1:0] r_waitCnt;
    logic [c_CNT_W-1:0] w_waitCntNext;
    logic [c_CNT_W-1:0] w_cntInc;
    logic               r_timeout;
    logic               w_timeoutNext;
    logic               w_memReq;
    logic               w_memStall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= c_ST_IDLE;
            r_waitCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitCntNext;
            r_timeout <= w_timeoutNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_waitCntNext = r_waitCnt;
        w_timeoutNext = r_timeout;
        w_memReq      = 1'b0;
        w_memStall    = 1'b0;
        w_cntInc      = r_waitCnt + c_CNT_W'(1);

        case (r_state)
            c_ST_IDLE: begin
                // An ack seen here is ignored: no request is outstanding.
                if (i_start && (i_memRd || i_memWr)) begin
                    w_memReq      = 1'b1;
                    w_memStall    = 1'b1;
                    w_waitCntNext = '0;
                    w_stateNext   = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                // start is not consulted: an issued access always completes.
                w_memReq      = 1'b1;
                w_memStall    = 1'b1;
                w_waitCntNext = w_cntInc;
                if (i_memAck) begin
                    w_stateNext = c_ST_DONE;
                end else if (w_cntInc == c_CNT_W'(MAX_WAIT)) begin
                    // w_cntInc counts this WAIT cycle, so the timeout fires
                    // at the end of the MAX_WAIT-th WAIT cycle.
                    w_timeoutNext = 1'b1;
                    w_stateNext   = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                // Single unstalled cycle; the access is never re-issued here.
                w_waitCntNext = '0;
                w_stateNext   = c_ST_IDLE;
            end
            default: begin
                w_waitCntNext = '0;
                w_stateNext   = c_ST_IDLE;
            end
        endcase
    end

    // The IDLE issue path is combinational on the inputs, so it must also be
    // gated by reset to keep the request low while reset is held.
    assign o_memReq   = w_memReq   & i_rst_n;
    assign o_memStall = w_memStall & i_rst_n;
    assign o_timeout  = r_timeout;

endmodule : mem_handshake_fsm
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Central stall/flush sequencer for the 5-stage pipeline.
//             Combines the data-memory wait handshake, the load-use hazard
//             and taken-branch flush into per-stage controls, in priority
//             order: memory stall > load-use > branch flush.
//  Config   : HAZARD_STATS_EN - when defined, adds saturating counters
//             stall_cyc_o (cycles with PCWrite_o=0) and flush_cnt_o
//             (IfId_flush_o pulses).
//  Ports    : clk_i, rst_i (async, active-low)
//             start_i                       - pipeline enable for new requests
//             ExMem_MemRd_i/ExMem_MemWr_i   - MEM-stage load/store
//             mem_ack_i / mem_req_o         - data memory handshake
//             IdEx_MemRd_i, IdEx_Rd_i       - EX-stage load and destination
//             IfId_Rs1_i, IfId_Rs2_i        - ID-stage sources
//             branch_taken_i                - ID-stage branch taken
//             PCWrite_o, IfId_stall_o, IfId_flush_o, IdEx_bubble_o,
//             mem_stall_o                   - stage controls
//             timeout_o                     - sticky request timeout
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = c_MAX_WAIT_DEF,
    parameter int unsigned REG_AW   = c_REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              ExMem_MemRd_i,
    input  logic              ExMem_MemWr_i,
    input  logic              mem_ack_i,
    input  logic              IdEx_MemRd_i,
    input  logic [REG_AW-1:0] IdEx_Rd_i,
    input  logic [REG_AW-1:0] IfId_Rs1_i,
    input  logic [REG_AW-1:0] IfId_Rs2_i,
    input  logic              branch_taken_i,
    output logic              mem_req_o,
    output logic              PCWrite_o,
    output logic              IfId_stall_o,
    output logic              IfId_flush_o,
    output logic              IdEx_bubble_o,
    output logic              mem_stall_o,
    output logic              timeout_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cyc_o,
    output logic [15:0]       flush_cnt_o
`endif
);

    logic w_memStall;
    logic w_loadUse;

    mem_handshake_fsm #(
        .MAX_WAIT (MAX_WAIT)
    ) u_memFsm (
        .i_clk      (clk_i),
        .i_rst_n    (rst_i),
        .i_start    (start_i),
        .i_memRd    (ExMem_MemRd_i),
        .i_memWr    (ExMem_MemWr_i),
        .i_memAck   (mem_ack_i),
        .o_memReq   (mem_req_o),
        .o_memStall (w_memStall),
        .o_timeout  (timeout_o)
    );

    assign mem_stall_o = w_memStall;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_loadUse = IdEx_MemRd_i && (IdEx_Rd_i != '0) &&
                       ((IdEx_Rd_i == IfId_Rs1_i) || (IdEx_Rd_i == IfId_Rs2_i));

    always_comb begin
        PCWrite_o     = 1'b1;
        IfId_stall_o  = 1'b0;
        IfId_flush_o  = 1'b0;
        IdEx_bubble_o = 1'b0;
        if (rst_i) begin
            if (w_memStall) begin
                // Freeze everything; a pending load-use or branch waits.
                PCWrite_o    = 1'b0;
                IfId_stall_o = 1'b1;
            end else if (w_loadUse) begin
                // Branch in ID is held and re-evaluated next cycle.
                PCWrite_o     = 1'b0;
                IfId_stall_o  = 1'b1;
                IdEx_bubble_o = 1'b1;
            end else if (branch_taken_i) begin
                IfId_flush_o = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stallCyc;
    logic [15:0] r_flushCnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stallCyc <= '0;
            r_flushCnt <= '0;
        end else begin
            if (!PCWrite_o && (r_stallCyc != '1)) begin
                r_stallCyc <= r_stallCyc + 32'd1;
            end
            if (IfId_flush_o && (r_flushCnt != '1)) begin
                r_flushCnt <= r_flushCnt + 16'd1;
            end
        end
    end

    assign stall_cyc_o = r_stallCyc;
    assign flush_cnt_o = r_flushCnt;
`endif

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl (MAX_WAIT=4):
//             table of single-cycle hazard vectors plus hand-written
//             sequences for the memory handshake, timeout and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TB_MAX_WAIT = 4;
    localparam int unsigned TB_REG_AW   = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, memRd, memWr, ack, ldEx, br;
    logic [4:0] rd, rs1, rs2;
    logic       req, pcw, ifStall, flush, bubble, stall, tout;
`ifdef HAZARD_STATS_EN
    logic [31:0] stallCyc;
    logic [15:0] flushCnt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .MAX_WAIT (TB_MAX_WAIT),
        .REG_AW   (TB_REG_AW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .ExMem_MemRd_i  (memRd),
        .ExMem_MemWr_i  (memWr),
        .mem_ack_i      (ack),
        .IdEx_MemRd_i   (ldEx),
        .IdEx_Rd_i      (rd),
        .IfId_Rs1_i     (rs1),
        .IfId_Rs2_i     (rs2),
        .branch_taken_i (br),
        .mem_req_o      (req),
        .PCWrite_o      (pcw),
        .IfId_stall_o   (ifStall),
        .IfId_flush_o   (flush),
        .IdEx_bubble_o  (bubble),
        .mem_stall_o    (stall),
        .timeout_o      (tout)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cyc_o    (stallCyc),
        .flush_cnt_o    (flushCnt)
`endif
    );

    typedef struct packed {
        logic       start;
        logic       memRd;
        logic       memWr;
        logic       ack;
        logic       ldEx;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
    } in_t;

    typedef struct packed {
        logic req;
        logic stall;
        logic pcw;
        logic ifStall;
        logic flush;
        logic bubble;
        logic tout;
    } exp_t;

    typedef struct packed {
        in_t  vin;
        exp_t vexp;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    exp_t  qExp[$];
    string qNm[$];
    vec_t  tbl[13];

    exp_t E_NONE, E_MEM, E_LU, E_BR, E_NONE_TO, E_MEM_TO;

    function automatic in_t mkIn(input logic st, input logic mr, input logic mw,
                                 input logic ak, input logic le, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic b);
        in_t v;
        v.start = st; v.memRd = mr; v.memWr = mw; v.ack = ak; v.ldEx = le;
        v.rd = d; v.rs1 = s1; v.rs2 = s2; v.br = b;
        return v;
    endfunction

    function automatic exp_t mkE(input logic rq, input logic sl, input logic pw,
                                 input logic is, input logic fl, input logic bu,
                                 input logic to);
        exp_t e;
        e.req = rq; e.stall = sl; e.pcw = pw; e.ifStall = is;
        e.flush = fl; e.bubble = bu; e.tout = to;
        return e;
    endfunction

    task automatic apply(input in_t v);
        start = v.start; memRd = v.memRd; memWr = v.memWr; ack = v.ack;
        ldEx = v.ldEx; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; br = v.br;
    endtask

    task automatic compare(input string nm, input exp_t e);
        exp_t act;
        act = mkE(req, stall, pcw, ifStall, flush, bubble, tout);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: {req,stall,pcw,ifStall,flush,bubble,timeout} actual=%b expected=%b",
                     nm, act, e);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at negedge.
    task automatic step(input in_t v, input exp_t e, input string nm);
        exp_t  x;
        string n;
        apply(v);
        qExp.push_back(e);
        qNm.push_back(nm);
        @(negedge clk);
        x = qExp.pop_front();
        n = qNm.pop_front();
        compare(n, x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        E_NONE    = mkE(0, 0, 1, 0, 0, 0, 0);
        E_MEM     = mkE(1, 1, 0, 1, 0, 0, 0);
        E_LU      = mkE(0, 0, 0, 1, 0, 1, 0);
        E_BR      = mkE(0, 0, 1, 0, 1, 0, 0);
        E_NONE_TO = mkE(0, 0, 1, 0, 0, 0, 1);
        E_MEM_TO  = mkE(1, 1, 0, 1, 0, 0, 1);

        //                   st mr mw ak le rd  rs1 rs2 br
        tbl[0]  = '{mkIn(1, 0, 0, 0, 0, 0,  0,  0,  0), E_NONE};
        tbl[1]  = '{mkIn(1, 0, 0, 0, 1, 5,  0,  5,  0), E_LU};
        tbl[2]  = '{mkIn(1, 0, 0, 0, 1, 0,  0,  0,  0), E_NONE};
        tbl[3]  = '{mkIn(1, 0, 0, 0, 1, 5,  5,  9,  0), E_LU};
        tbl[4]  = '{mkIn(1, 0, 0, 0, 1, 5,  6,  7,  0), E_NONE};
        tbl[5]  = '{mkIn(1, 0, 0, 0, 0, 5,  5,  5,  0), E_NONE};
        tbl[6]  = '{mkIn(1, 0, 0, 0, 0, 0,  0,  0,  1), E_BR};
        tbl[7]  = '{mkIn(1, 0, 0, 0, 1, 31, 0,  31, 1), E_LU};
        tbl[8]  = '{mkIn(1, 0, 0, 1, 0, 0,  0,  0,  0), E_NONE};
        tbl[9]  = '{mkIn(1, 0, 0, 0, 0, 0,  0,  0,  0), E_NONE};
        tbl[10] = '{mkIn(0, 1, 0, 0, 0, 0,  0,  0,  0), E_NONE};
        tbl[11] = '{mkIn(0, 0, 1, 0, 0, 0,  0,  0,  1), E_BR};
        tbl[12] = '{mkIn(1, 0, 0, 0, 0, 0,  0,  0,  0), E_NONE};

        // Reset held with every hazard source active
        rst = 1'b0;
        apply(mkIn(1, 1, 0, 1, 1, 5, 5, 0, 1));
        #12;
        compare("reset_outputs", E_NONE);
        @(posedge clk);
        #1;
        apply(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].vin, tbl[i].vexp, $sformatf("vec%0d", i));
        end

        // Load, ack three cycles after request; start dropped during WAIT
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM,  "A_issue");
        step(mkIn(0, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM,  "A_wait1");
        step(mkIn(0, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM,  "A_wait2");
        step(mkIn(0, 1, 0, 1, 0, 0, 0, 0, 0), E_MEM,  "A_wait3_ack");
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_NONE, "A_done_no_reissue");
        step(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), E_NONE, "A_idle");

        // Load-use with branch, then branch alone
        step(mkIn(1, 0, 0, 0, 1, 5, 5, 0, 1), E_LU, "C_lu_br");
        step(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 1), E_BR, "C_br");

        // Store pending together with load-use
        step(mkIn(1, 0, 1, 0, 1, 3, 3, 0, 0), E_MEM,  "B_store_lu");
        step(mkIn(1, 0, 1, 1, 1, 3, 3, 0, 0), E_MEM,  "B_wait_ack");
        step(mkIn(1, 0, 0, 0, 1, 3, 3, 0, 0), E_LU,   "B_done_bubble");
        step(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), E_NONE, "B_idle");

        // Timeout after MAX_WAIT=4 WAIT cycles, then sticky
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM,     "D_issue");
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM,     "D_wait1");
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM,     "D_wait2");
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM,     "D_wait3");
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM,     "D_wait4");
        step(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), E_NONE_TO, "D_done_timeout");
        step(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), E_NONE_TO, "D_idle_sticky");
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM_TO,  "D2_issue");
        step(mkIn(1, 1, 0, 1, 0, 0, 0, 0, 0), E_MEM_TO,  "D2_ack");
        step(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), E_NONE_TO, "D2_done_sticky");

        // Reset asserted mid-WAIT
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM_TO, "E_issue");
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM_TO, "E_wait");
        rst = 1'b0;
        #1;
        compare("E_rst_req_drop", E_NONE);
        @(posedge clk);
        #1;
        apply(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        step(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), E_NONE, "E_after_rst1");
        step(mkIn(1, 0, 0, 1, 0, 0, 0, 0, 0), E_NONE, "E_after_rst2");
        step(mkIn(1, 1, 0, 0, 0, 0, 0, 0, 0), E_MEM,  "E_new_req");
        step(mkIn(1, 1, 0, 1, 0, 0, 0, 0, 0), E_MEM,  "E_new_ack");
        step(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0), E_NONE, "E_new_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
